// File: rtl/jk_seq_driver.sv
// rtl/jk_seq_driver.sv - command FIFO driven J/K stimulus stage with reference-model check
module jk_seq_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             q_in,
    input  logic             err_clr,
    output logic             j,
    output logic             k,
    output logic             done,
    output logic             busy,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

    state_t               state, state_nxt;
    logic [CNT_W+1:0]     mem [DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 full, empty, push, pop;
    logic [CNT_W+1:0]     head;
    logic [1:0]           op_r;
    logic [CNT_W-1:0]     rem_r;
    logic                 q_exp;
    logic                 j_nxt, k_nxt;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign done      = (state == CHECK);
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_cnt};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        j_nxt     = 1'b0;
        k_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = APPLY;
                    j_nxt     = head[CNT_W+1];
                    k_nxt     = head[CNT_W];
                end
            end
            APPLY: begin
                if (rem_r == '0) begin
                    state_nxt = CHECK;
                end else begin
                    j_nxt = op_r[1];
                    k_nxt = op_r[0];
                end
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            j     <= 1'b0;
            k     <= 1'b0;
            op_r  <= '0;
            rem_r <= '0;
            q_exp <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            j     <= j_nxt;
            k     <= k_nxt;
            if (pop) begin
                op_r  <= head[CNT_W+1:CNT_W];
                rem_r <= head[CNT_W-1:0];
            end
            // Model advances in lockstep with the downstream flip-flop.
            if (state == APPLY) begin
                q_exp <= (j & ~q_exp) | (~k & q_exp);
                rem_r <= rem_r - CNT_ONE;
            end
            if (state == CHECK && q_in != q_exp) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jk_seq_driver.sv
// tb/tb_jk_seq_driver.sv - directed scoreboard bench for jk_seq_driver
module tb_jk_seq_driver;
    logic       clk = 1'b0;
    logic       rstn, cmd_valid, cmd_ready, q_in, err_clr;
    logic [1:0] cmd_op;
    logic [3:0] cmd_cnt;
    logic       j, k, done, busy, err;
    logic       q_ff, force_q0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic sb[$];
    logic q_ref = 1'b0;
    logic err_m = 1'b0;
    logic chk_pend = 1'b0;
    logic mism = 1'b0;
    int base0, base1;

    always #5 clk = ~clk;

    jk_seq_driver #(.DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .q_in(q_in), .err_clr(err_clr),
        .j(j), .k(k), .done(done), .busy(busy), .err(err)
    );

    // Downstream J/K flip-flop sharing rstn; q_in can be forced low to create mismatches.
    always @(posedge clk) begin
        if (!rstn) q_ff <= 1'b0;
        else       q_ff <= (j & ~q_ff) | (~k & q_ff);
    end
    assign q_in = force_q0 ? 1'b0 : q_ff;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rstn)                  err_m = 1'b0;
        else if (chk_pend && mism)  err_m = 1'b1;
        else if (err_clr)           err_m = 1'b0;
        chk_pend = 1'b0;
    end

    always @(negedge clk) begin
        chk("err_track", err, err_m);
        if (!rstn) begin
            sb.delete();
            q_ref = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                for (int i = 0; i <= int'(cmd_cnt); i++)
                    q_ref = (cmd_op[1] & ~q_ref) | (~cmd_op[0] & q_ref);
                sb.push_back(q_ref);
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    logic e;
                    e = sb.pop_front();
                    chk("q_final", q_ff, e);
                    mism = (q_in !== e);
                    chk_pend = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] cnt);
        cmd_op = op;
        cmd_cnt = cnt;
        cmd_valid = 1'b1;
        for (int n = 0; n < 200 && !cmd_ready; n++) step();
        chk("send_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 400 && busy; n++) step();
        chk("idle_timeout", busy, 0);
        step();
    endtask

    initial begin
        rstn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cmd_valid = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_cnt   = 4'($urandom);
            err_clr   = 1'($urandom);
            force_q0  = 1'($urandom);
            step();
        end
        chk("rst_j", j, 0);
        chk("rst_k", k, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        cmd_valid = 1'b0; err_clr = 1'b0; force_q0 = 1'b0;
        cmd_op = 2'b00; cmd_cnt = 4'd0;
        rstn = 1'b1;
        step();

        // Single set: accepted at T, drive in T+2, done in T+3
        send(2'b10, 4'd0);
        chk("set_t1_j", j, 0);
        step();
        chk("set_t2_j", j, 1);
        chk("set_t2_k", k, 0);
        chk("set_t2_done", done, 0);
        step();
        chk("set_t3_j", j, 0);
        chk("set_t3_done", done, 1);
        chk("set_t3_qin", q_in, 1);
        step();
        chk("set_t4_done", done, 0);
        chk("set_t4_err", err, 0);
        wait_idle();

        send(2'b01, 4'd0);
        wait_idle();
        chk("clr_q", q_ff, 0);

        // Toggle run of three cycles from q=0
        send(2'b11, 4'd2);
        step();
        chk("tog_t2_jk", {j, k}, 2'b11);
        step();
        chk("tog_t3_q", q_in, 1);
        step();
        chk("tog_t4_q", q_in, 0);
        chk("tog_t4_done", done, 0);
        step();
        chk("tog_t5_q", q_in, 1);
        chk("tog_t5_done", done, 1);
        wait_idle();
        chk("tog_err", err, 0);

        // FIFO full, wrap and held sixth command
        base0 = done_cnt;
        send(2'b00, 4'd15);
        cmd_valid = 1'b1;
        cmd_op = 2'b10; cmd_cnt = 4'd1; step();
        cmd_op = 2'b11; cmd_cnt = 4'd2; step();
        cmd_op = 2'b01; cmd_cnt = 4'd0; step();
        cmd_op = 2'b11; cmd_cnt = 4'd3; step();
        chk("full_ready", cmd_ready, 0);
        chk("full_busy", busy, 1);
        cmd_op = 2'b10; cmd_cnt = 4'd1;
        base1 = done_cnt;
        for (int n = 0; n < 200 && !cmd_ready; n++) step();
        chk("sixth_ready", cmd_ready, 1);
        chk("sixth_after_pop", done_cnt - base1, 1);
        step();
        cmd_valid = 1'b0;
        wait_idle();
        chk("six_dones", done_cnt - base0, 6);

        // Mismatch handling and sticky err
        force_q0 = 1'b1;
        send(2'b10, 4'd0);
        wait_idle();
        chk("mism_err", err, 1);
        force_q0 = 1'b0;
        send(2'b01, 4'd1);
        wait_idle();
        chk("err_sticky", err, 1);
        force_q0 = 1'b1;
        send(2'b10, 4'd0);
        step();
        step();
        chk("coinc_done", done, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("coinc_err", err, 1);
        wait_idle();
        force_q0 = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err", err, 0);

        // Reset during the third APPLY cycle
        send(2'b11, 4'd7);
        step();
        chk("mid_jk", {j, k}, 2'b11);
        step();
        step();
        base1 = done_cnt;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("mid_j", j, 0);
        chk("mid_k", k, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", cmd_ready, 1);
        chk("mid_done", done, 0);
        step();
        step();
        chk("mid_no_done", done_cnt - base1, 0);
        send(2'b10, 4'd0);
        wait_idle();
        chk("post_rst_err", err, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jk_seq_driver.md
# jk_seq_driver

Command-driven stimulus stage sitting directly upstream of the `jk_ff` flip-flop. It accepts {op, count} commands over a valid/ready handshake and buffers them in a small FIFO. It drives the flip-flop's `j`/`k` inputs for the requested number of cycles, then checks the flip-flop's `q` against an internal reference model. A sticky error flag reports any mismatch.

## Interface
- `DEPTH`, 4, command FIFO depth; power of two, ≥2
- `CNT_W`, 4, width of the repeat-count field
- `clk`  in  1  clock; all state updates on rising edge
- `rstn`  in  1  reset; synchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  FIFO can accept; equals !full
- `cmd_op`  in  2  {j,k} pattern: 00 hold, 01 clear, 10 set, 11 toggle
- `cmd_cnt`  in  CNT_W  apply cycles minus one (0 → 1 cycle, max → 2^CNT_W cycles)
- `q_in`  in  1  `q` fed back from the downstream flip-flop
- `err_clr`  in  1  clears sticky `err`
- `j`  out  1  registered, to flip-flop `j`
- `k`  out  1  registered, to flip-flop `k`
- `done`  out  1  one-cycle pulse per completed command (high in CHECK)
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty
- `err`  out  1  sticky mismatch flag

## Operation
- Push occurs when `cmd_valid & cmd_ready`: {cmd_op, cmd_cnt} is written at FIFO tail.
- Push and pop in the same cycle is legal when not full; occupancy is unchanged.
- When full, `cmd_ready` is 0 and no push occurs; pointers wrap modulo DEPTH.
- FSM states are IDLE, APPLY and CHECK.
- IDLE: `j`=`k`=0. If the FIFO is non-empty, pop the head into `op_r`/`rem_r` and go to APPLY.
- APPLY: drive {`j`,`k`} = `op_r`.
  - Each cycle, update the model: `q_exp` <= (j & ~q_exp) | (~k & q_exp).
  - Decrement `rem_r`; when `rem_r`==0, go to CHECK.
- CHECK: `j`=`k`=0 and `done`=1.
  - If `q_in` != `q_exp`, set `err`.
  - Always return to IDLE. No back-to-back pop from CHECK.
- `err` clear/set priority: `err_clr` clears `err`; a mismatch in the same cycle sets it (set wins).
- Reset (`rstn`=0 at an edge), including mid-APPLY:
  - FIFO is emptied and the FSM goes to IDLE.
  - `j`=`k`=0, `q_exp`=0, `err`=0, `done`=0.
  - `q_exp`=0 matches the flip-flop's reset value, since both share `rstn`.
- Reset values of outputs: `cmd_ready`=1, `j`=0, `k`=0, `done`=0, `busy`=0, `err`=0.

## Timing
- Command accepted at edge T into an empty FIFO with the FSM in IDLE:
  - popped at edge T+1;
  - `j`/`k` driven during cycles T+2 … T+2+cnt;
  - CHECK and `done` in cycle T+3+cnt;
  - `err` updated at the end of that cycle.
- `q_in` is sampled in CHECK. It reflects the flip-flop's update at the edge ending the last APPLY cycle.
- Per-command occupancy of the FSM is cnt+3 cycles (IDLE, APPLY×(cnt+1), CHECK).
- `cmd_ready` is combinational from occupancy. Once the FIFO has an empty slot, it rises in the cycle after the pop edge.
- `busy` is combinational from state and occupancy.

## Test plan
- Reset: hold `rstn`=0 for 2 cycles with random inputs → `j`=`k`=0, `cmd_ready`=1, `busy`=0, `err`=0, `done`=0.
- Single set: op=10, cnt=0 accepted at T, `q_in` tied to a real `jk_ff`:
  - → `j`=1, `k`=0 only in cycle T+2;
  - `done` in T+3;
  - `q_in`=1, `err`=0.
- Toggle run: op=11, cnt=2 from q=0 → q goes 1, 0, 1; `q_exp`=1 in CHECK; `done` at T+5; `err`=0.
- FIFO full/wrap:
  - push hold with cnt=15, then 4 more commands;
  - → `cmd_ready`=0 after the 4th is stored;
  - a 6th held `cmd_valid` is accepted the cycle after the next pop;
  - all 6 complete in order (6 `done` pulses).
- Mismatch:
  - `q_in` forced to 0, op=10 → `err`=1 after CHECK;
  - `err` stays 1 across the next command;
  - `err_clr` coincident with another mismatch → `err` remains 1;
  - `err_clr` alone → 0.
- Reset mid-APPLY: op=11, cnt=7, `rstn`=0 at the 3rd APPLY cycle → next cycle `j`=`k`=0, `busy`=0, FIFO empty, no `done`.
